// File: rtl/adder_arbiter.sv
// Two-client round-robin front end for an external fixed-latency pipelined adder.
// Credit-gated issue, a tag pipeline matched to the adder latency, and per-client FWFT result FIFOs.
module adder_arbiter #(
  parameter int WIDTH      = 32,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // req*_ready is a combinational grant and may depend on req*_valid; rsp*_valid never
  // depends on rsp*_ready.

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  logic [1:0]       req_valid;
  logic [1:0]       req_cin;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];

  assign req_valid = {req1_valid, req0_valid};
  assign req_cin   = {req1_cin, req0_cin};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;

  logic [CW-1:0] credit_q [2];
  logic [CW-1:0] credit_d [2];
  logic          last_grant_q;
  logic          last_grant_d;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic          grant_any;
  logic          grant_id;

  logic [LAT-1:0] tag_v_q;
  logic [LAT-1:0] tag_id_q;

  logic [DW-1:0] mem_q    [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] count_q  [2];
  logic [CW-1:0] count_d  [2];
  logic [1:0]    wr_en;
  logic [1:0]    pop;
  logic [1:0]    empty;
  logic [1:0]    full;
  logic [DW-1:0] head [2];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) return '0;
    return p + PW'(1);
  endfunction

  // Arbitration: the client that did not win last time gets priority on contention.
  always_comb begin
    elig  = '0;
    grant = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && (credit_q[i] != '0) && !reset;
    end
    if (elig[0] && (!elig[1] || last_grant_q)) grant[0] = 1'b1;
    else if (elig[1])                           grant[1] = 1'b1;
    grant_any    = |grant;
    grant_id     = grant[1];
    last_grant_d = grant_any ? grant_id : last_grant_q;
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (grant_any) begin
      add_a   = req_a[grant_id];
      add_b   = req_b[grant_id];
      add_cin = req_cin[grant_id];
    end
  end

  // FIFO status, credit and pointer next-state.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i]    = (count_q[i] == '0);
      full[i]     = (count_q[i] == DEPTH_C);
      wr_en[i]    = tag_v_q[LAT-1] && (tag_id_q[LAT-1] == 1'(i));
      pop[i]      = !empty[i] && rsp_ready[i];
      head[i]     = mem_q[i][rd_ptr_q[i]];
      wr_ptr_d[i] = wr_en[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i] ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      count_d[i]  = count_q[i];
      credit_d[i] = credit_q[i];
      case ({wr_en[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
      case ({grant[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - CW'(1);
        2'b01:   credit_d[i] = credit_q[i] + CW'(1);
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        credit_q[i] <= DEPTH_C;
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      tag_v_q[0]   <= grant_any;
      tag_id_q[0]  <= grant_id;
      for (int s = 1; s < LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      for (int i = 0; i < 2; i++) begin
        credit_q[i] <= credit_d[i];
        count_q[i]  <= count_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= {add_cout, add_sum};
    end
  end

  assign rsp0_valid = !empty[0];
  assign rsp1_valid = !empty[1];
  assign rsp0_sum   = empty[0] ? '0 : head[0][WIDTH-1:0];
  assign rsp0_cout  = empty[0] ? 1'b0 : head[0][WIDTH];
  assign rsp1_sum   = empty[1] ? '0 : head[1][WIDTH-1:0];
  assign rsp1_cout  = empty[1] ? 1'b0 : head[1][WIDTH];

  // Credits make a write into a full FIFO impossible; catch it if that ever breaks.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ovf
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_en[gi] && full[gi]));
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: behavioural pipelined adder, per-client expected queues
// filled on accepted requests and drained on popped responses.
`timescale 1ns/1ps
module tb_adder_arbiter;
  localparam int WIDTH      = 32;
  localparam int LAT        = 4;
  localparam int FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req0_cin;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready, rsp0_cout;
  logic             rsp1_valid, rsp1_ready, rsp1_cout;
  logic [WIDTH-1:0] rsp0_sum, rsp1_sum;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;

  adder_arbiter #(.WIDTH(WIDTH), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural adder: samples operands each edge, result appears LAT cycles later.
  logic [WIDTH:0] pipe_q [LAT];
  always @(posedge clk) begin
    pipe_q[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
  end
  assign add_sum  = pipe_q[LAT-1][WIDTH-1:0];
  assign add_cout = pipe_q[LAT-1][WIDTH];

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;
  int rsp_cnt0 = 0;
  int rsp_cnt1 = 0;
  logic [WIDTH:0] exp_q0[$];
  logic [WIDTH:0] exp_q1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] add_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Scoreboard: push on accepted request, pop and compare on consumed response.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (req0_ready && req1_ready) chk("dual_grant", {req0_ready, req1_ready}, 2'b01);
      if (req0_valid && req0_ready) begin
        exp_q0.push_back(add_ref(req0_a, req0_b, req0_cin));
        chk("add_ops0", {add_a, add_b}, {req0_a, req0_b});
        chk("add_cin0", 64'(add_cin), 64'(req0_cin));
      end else if (req1_valid && req1_ready) begin
        exp_q1.push_back(add_ref(req1_a, req1_b, req1_cin));
        chk("add_ops1", {add_a, add_b}, {req1_a, req1_b});
        chk("add_cin1", 64'(add_cin), 64'(req1_cin));
      end else begin
        chk("add_idle", {add_a, add_b}, 64'd0);
      end
      if (rsp0_valid && rsp0_ready) begin
        rsp_cnt0++;
        if (exp_q0.size() == 0) chk("rsp0_unexpected", 64'(rsp0_valid), 64'd0);
        else begin
          e = exp_q0.pop_front();
          chk("rsp0_data", 64'({rsp0_cout, rsp0_sum}), 64'(e));
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        rsp_cnt1++;
        if (exp_q1.size() == 0) chk("rsp1_unexpected", 64'(rsp1_valid), 64'd0);
        else begin
          e = exp_q1.pop_front();
          chk("rsp1_data", 64'({rsp1_cout, rsp1_sum}), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Call right after the accept cycle's tick; returns cycles from accept to rsp_valid.
  task automatic wait_rsp(input int id, input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if ((id == 0 && rsp0_valid) || (id == 1 && rsp1_valid)) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  task automatic rand0();
    req0_a = $urandom(); req0_b = $urandom(); req0_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic rand1();
    req1_a = $urandom(); req1_b = $urandom(); req1_cin = 1'($urandom_range(0, 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int acc0;
    int base0, base1;
    logic acc0_last, acc1_last;

    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h1; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    chk("rst_rsp_data", {rsp0_cout, rsp0_sum, rsp1_cout}, 64'd0);
    chk("rst_rsp1_sum", 64'(rsp1_sum), 64'd0);
    chk("rst_add", {add_a, add_b}, 64'd0);
    chk("rst_add_cin", 64'(add_cin), 64'd0);
    tick();
    reset = 1'b0;

    // Single op with full carry propagation, granted in the first cycle after reset.
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 1'b0;
    @(negedge clk);
    chk("single_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    wait_rsp(0, 10, lat);
    chk("single_latency", 64'(lat), 64'd5);
    chk("single_sum", {rsp0_cout, rsp0_sum}, {1'b1, 32'h0000_0000});
    chk("single_rsp1_idle", 64'(rsp1_valid), 64'd0);
    tick();

    // Carry-in on client 1.
    req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'h0; req1_cin = 1'b1;
    @(negedge clk);
    chk("cin_ready", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    wait_rsp(1, 10, lat);
    chk("cin_latency", 64'(lat), 64'd5);
    chk("cin_sum", {rsp1_cout, rsp1_sum}, {1'b0, 32'h8000_0000});
    chk("cin_rsp0_idle", 64'(rsp0_valid), 64'd0);
    tick();

    // Contention: grants alternate starting with client 0.
    base0 = rsp_cnt0; base1 = rsp_cnt1;
    rand0(); rand1();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rr_ready0_c%0d", i), 64'(req0_ready), 64'((i % 2) == 0));
      chk($sformatf("rr_ready1_c%0d", i), 64'(req1_ready), 64'((i % 2) == 1));
      acc0_last = req0_ready; acc1_last = req1_ready;
      tick();
      if (acc0_last) rand0();
      if (acc1_last) rand1();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(12);
    chk("rr_count0", 64'(rsp_cnt0 - base0), 64'd4);
    chk("rr_count1", 64'(rsp_cnt1 - base1), 64'd4);

    // Backpressure on client 0: exactly FIFO_DEPTH accepts, client 1 still served.
    acc0 = 0;
    rsp0_ready = 1'b0;
    rand0();
    req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) begin rand1(); req1_valid = 1'b1; end
      @(negedge clk);
      if (i == 6) chk("bp_req1_ready", 64'(req1_ready), 64'd1);
      acc0_last = req0_ready;
      if (req0_ready) acc0++;
      tick();
      req1_valid = 1'b0;
      if (acc0_last) rand0();
    end
    chk("bp_accepts", 64'(acc0), 64'(FIFO_DEPTH));
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_valid", 64'(rsp0_valid), 64'd1);
    chk("bp_ready_in_pop_cycle", 64'(req0_ready), 64'd0);
    tick();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(req0_ready), 64'd1);
    tick();
    rand0();
    @(negedge clk);
    chk("bp_ready_exhausted", 64'(req0_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    idle(15);
    chk("bp_drained0", 64'(exp_q0.size()), 64'd0);
    chk("bp_drained1", 64'(exp_q1.size()), 64'd0);

    // Simultaneous pop and issue with one credit left.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand0();
      @(negedge clk);
      chk($sformatf("pi_fill_ready%0d", i), 64'(req0_ready), 64'd1);
      tick();
    end
    req0_valid = 1'b0;
    idle(8);
    rand0(); req0_valid = 1'b1; rsp0_ready = 1'b1;
    @(negedge clk);
    chk("pi_pop_issue_ready", 64'(req0_ready), 64'd1);
    chk("pi_pop_issue_valid", 64'(rsp0_valid), 64'd1);
    tick();
    rand0(); rsp0_ready = 1'b0;
    @(negedge clk);
    chk("pi_credit_kept", 64'(req0_ready), 64'd1);
    tick();
    rand0();
    @(negedge clk);
    chk("pi_credit_gone", 64'(req0_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    idle(8);
    rsp0_ready = 1'b1;
    idle(10);
    chk("pi_drained", 64'(exp_q0.size()), 64'd0);

    // Reset with three ops in flight.
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand0();
      tick();
    end
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", i), {rsp0_valid, rsp1_valid}, 2'b00);
      tick();
    end
    rand0(); req0_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    wait_rsp(0, 10, lat);
    chk("post_rst_latency", 64'(lat), 64'd5);
    tick();
    idle(2);
    acc0 = 0;
    rsp0_ready = 1'b0;
    rand0(); req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc0_last = req0_ready;
      if (req0_ready) acc0++;
      tick();
      if (acc0_last) rand0();
    end
    chk("post_rst_credits", 64'(acc0), 64'(FIFO_DEPTH));
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    idle(12);
    chk("final_q0_empty", 64'(exp_q0.size()), 64'd0);
    chk("final_q1_empty", 64'(exp_q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
